// File: rtl/biquad_cfg_ctrl.sv
// ----------------------------------------------------------------------------
// BiquadCfgCtrl : coefficient configuration controller for a cascade of
// NSTAGE biquad sections.
//
// Coefficients are written one at a time into a shadow bank while the filter
// keeps running on the active bank. A commit request waits for the next
// sample boundary (smp_en) and then copies the whole shadow bank into the
// active bank in a single edge, so a section never runs with a half-updated
// coefficient set. After the swap the sections are held in reset for
// FLUSH_CYC cycles to clear stale state, and done pulses once on the return
// to IDLE.
//
// Parameters
//   NSTAGE    : number of cascaded biquad sections
//   FLUSH_CYC : cycles flt_rst is held after a swap (1..15)
//
// Ports
//   CLK       in   1            clock, rising edge
//   RST       in   1            asynchronous active-high reset
//   wr_valid  in   1            coefficient write request
//   wr_ready  out  1            write accept (high only in IDLE)
//   wr_stage  in   2            target section index
//   wr_sel    in   3            0=b_0 1=b_1 2=b_2 3=a_1 4=a_2
//   wr_data   in   16           signed coefficient value
//   commit    in   1            request to apply the shadow bank
//   smp_en    in   1            sample-boundary strobe
//   coef_out  out  80*NSTAGE    active coefficients, section s at [80s+79:80s],
//                               ordered b_0 (LSBs), b_1, b_2, a_1, a_2
//   flt_rst   out  1            reset to all biquad sections
//   busy      out  1            high while waiting for a sample or flushing
//   done      out  1            one-cycle pulse when a commit completes
//   err       out  1            sticky illegal-write flag
// ----------------------------------------------------------------------------
module biquad_cfg_ctrl #(
    parameter int NSTAGE    = 4,
    parameter int FLUSH_CYC = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [1:0]               wr_stage,
    input  logic [2:0]               wr_sel,
    input  logic signed [15:0]       wr_data,
    input  logic                     commit,
    input  logic                     smp_en,
    output logic [80*NSTAGE-1:0]     coef_out,
    output logic                     flt_rst,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_SMP = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    state_t             state;
    logic [3:0]         flushCnt;
    logic               dirty;
    logic               fltReg;
    logic signed [15:0] shadowBank [NSTAGE][5];
    logic signed [15:0] activeBank [NSTAGE][5];

    logic wrAccept;
    logic wrLegal;
    logic wrGood;
    logic wrBad;
    logic commitGo;
    logic swapNow;

    // Classify the write handshake. An out-of-range select or section index
    // is still accepted (the handshake completes) but must not touch any
    // bank; it only raises the sticky error. A commit is taken when there is
    // something to apply, counting a legal write landing on the same edge.
    always_comb begin
        wrAccept = wr_valid && wr_ready;
        wrLegal  = (wr_sel <= 3'd4) && (int'(wr_stage) < NSTAGE);
        wrGood   = wrAccept && wrLegal;
        wrBad    = wrAccept && !wrLegal;
        commitGo = (state == IDLE) && commit && (dirty || wrGood);
        swapNow  = (state == WAIT_SMP) && smp_en;
    end

    // Shadow bank: written only by legal accepted writes. Its contents are
    // kept across commits so a partial rewrite only changes what was written.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int s = 0; s < NSTAGE; s++) begin
                for (int k = 0; k < 5; k++) begin
                    shadowBank[s][k] <= '0;
                end
            end
        end else if (wrGood) begin
            for (int s = 0; s < NSTAGE; s++) begin
                for (int k = 0; k < 5; k++) begin
                    if (s == int'(wr_stage) && k == int'(wr_sel)) begin
                        shadowBank[s][k] <= wr_data;
                    end
                end
            end
        end
    end

    // Active bank: the only thing that ever changes it is the swap on the
    // first sample boundary after a commit, and all sections move together.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int s = 0; s < NSTAGE; s++) begin
                for (int k = 0; k < 5; k++) begin
                    activeBank[s][k] <= '0;
                end
            end
        end else if (swapNow) begin
            for (int s = 0; s < NSTAGE; s++) begin
                for (int k = 0; k < 5; k++) begin
                    activeBank[s][k] <= shadowBank[s][k];
                end
            end
        end
    end

    // Control FSM with registered outputs. Each output is loaded with the
    // value it must have in the state being entered, so wr_ready, busy and
    // the flush reset line up exactly with the state. The flush counter
    // starts at FLUSH_CYC-1 and the exit happens on the edge where it reads
    // zero, giving exactly FLUSH_CYC cycles of flt_rst. wr_ready comes up on
    // the first edge after reset release.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            flushCnt <= '0;
            dirty    <= 1'b0;
            err      <= 1'b0;
            fltReg   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            wr_ready <= 1'b0;
        end else begin
            done <= 1'b0;
            if (wrBad) begin
                err <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (wrGood) begin
                        dirty <= 1'b1;
                    end
                    if (commitGo) begin
                        state    <= WAIT_SMP;
                        busy     <= 1'b1;
                        wr_ready <= 1'b0;
                    end else begin
                        wr_ready <= 1'b1;
                    end
                end
                WAIT_SMP: begin
                    if (smp_en) begin
                        state    <= FLUSH;
                        dirty    <= 1'b0;
                        flushCnt <= 4'(FLUSH_CYC - 1);
                        fltReg   <= 1'b1;
                    end
                end
                FLUSH: begin
                    if (flushCnt == 4'd0) begin
                        state    <= IDLE;
                        fltReg   <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        wr_ready <= 1'b1;
                    end else begin
                        flushCnt <= flushCnt - 4'd1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    fltReg   <= 1'b0;
                    busy     <= 1'b0;
                    wr_ready <= 1'b0;
                end
            endcase
        end
    end

    // The section reset must also follow RST directly, without waiting for
    // a clock edge, so the datapath is cleared the moment reset is applied.
    assign flt_rst = fltReg | RST;

    // Flatten the active bank onto the output bus, b_0 in the low bits of
    // each 80-bit section slice.
    always_comb begin
        coef_out = '0;
        for (int s = 0; s < NSTAGE; s++) begin
            for (int k = 0; k < 5; k++) begin
                coef_out[80*s + 16*k +: 16] = activeBank[s][k];
            end
        end
    end

endmodule
